// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: folds fetch waits, data-memory waits,
// load-use hazards, MEM-stage redirects and halt draining into one
// per-cycle latch control vector, with saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             dREN_ex,
  input  logic [4:0]       Rt_ex,
  input  logic [4:0]       Rs_id,
  input  logic [4:0]       Rt_id,
  input  logic             redirect_mem,
  input  logic             halt_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             enable_ifid,
  output logic             enable_idex,
  output logic             enable_exmem,
  output logic             enable_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             dwait_req;
  logic             load_use;
  logic             freeze;
  logic             redirect_evt;

  assign dwait_req = (dREN_mem | dWEN_mem) & ~dhit;
  assign load_use  = dREN_ex & (Rt_ex != 5'd0) &
                     ((Rt_ex == Rs_id) | (Rt_ex == Rt_id));

  // Same-cycle control vector and next state from state and hazard inputs.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    enable_ifid  = 1'b0;
    enable_idex  = 1'b0;
    enable_exmem = 1'b0;
    enable_memwb = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    flush_exmem  = 1'b0;
    halted       = 1'b0;
    redirect_evt = 1'b0;
    freeze       = 1'b0;

    if (RST) begin
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      halted = 1'b1;
    end else begin
      // In DWAIT the access that started the wait is still outstanding.
      freeze = (state_q == ST_DWAIT) ? ~dhit : dwait_req;
      if (freeze) begin
        if (state_q == ST_RUN) state_d = ST_DWAIT;
      end else begin
        if (redirect_mem) begin
          // Enables stay high; the flushes turn the advance into bubbles.
          pc_en        = 1'b1;
          enable_ifid  = 1'b1;
          enable_idex  = 1'b1;
          enable_exmem = 1'b1;
          enable_memwb = 1'b1;
          flush_ifid   = 1'b1;
          flush_idex   = 1'b1;
          flush_exmem  = 1'b1;
          redirect_evt = 1'b1;
        end else if (load_use) begin
          enable_idex  = 1'b1;
          enable_exmem = 1'b1;
          enable_memwb = 1'b1;
          flush_idex   = 1'b1;
        end else if (!ihit) begin
          enable_ifid  = 1'b1;
          enable_idex  = 1'b1;
          enable_exmem = 1'b1;
          enable_memwb = 1'b1;
          flush_ifid   = 1'b1;
        end else begin
          pc_en        = 1'b1;
          enable_ifid  = 1'b1;
          enable_idex  = 1'b1;
          enable_exmem = 1'b1;
          enable_memwb = 1'b1;
        end

        unique case (state_q)
          ST_RUN:   if (halt_mem) state_d = ST_DRAIN;
          ST_DWAIT: state_d = ST_RUN;
          ST_DRAIN: begin
            // Stop fetching and keep the younger stages empty while halt retires.
            pc_en      = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (halt_wb) state_d = ST_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && (state_q != ST_HALT) && (stall_q != CNT_MAX))
      stall_d = stall_q + CNT_W'(1);
    if (redirect_evt && (flush_q != CNT_MAX))
      flush_d = flush_q + CNT_W'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (4-bit counters).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control vector order: pc_en, en_ifid, en_idex, en_exmem, en_memwb,
  // fl_ifid, fl_idex, fl_exmem, halted.
  localparam logic [8:0] V_OFF    = 9'h000;
  localparam logic [8:0] V_NORM   = 9'h1F0;
  localparam logic [8:0] V_LU     = 9'h074;
  localparam logic [8:0] V_MISS   = 9'h0F8;
  localparam logic [8:0] V_REDIR  = 9'h1FE;
  localparam logic [8:0] V_DRAIN  = 9'h0FC;
  localparam logic [8:0] V_HALTED = 9'h001;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
  logic [4:0] Rt_ex, Rs_id, Rt_id;
  logic redirect_mem, halt_mem, halt_wb;
  logic pc_en, enable_ifid, enable_idex, enable_exmem, enable_memwb;
  logic flush_ifid, flush_idex, flush_exmem, halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [8:0] ctrl;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign ctrl = {pc_en, enable_ifid, enable_idex, enable_exmem, enable_memwb,
                 flush_ifid, flush_idex, flush_exmem, halted};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
    .Rt_ex(Rt_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .redirect_mem(redirect_mem), .halt_mem(halt_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .enable_ifid(enable_ifid), .enable_idex(enable_idex),
    .enable_exmem(enable_exmem), .enable_memwb(enable_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs were applied at the falling edge; compare mid low phase.
  task automatic cyc(input string tag, input logic [8:0] ev, input int es, input int ef);
    #2;
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(ev));
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(es));
    chk({tag, ".flush"}, 32'(flush_events), 32'(ef));
  endtask

  task automatic idle_inputs();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
    dREN_ex = 1'b0; Rt_ex = 5'd0; Rs_id = 5'd0; Rt_id = 5'd0;
    redirect_mem = 1'b0; halt_mem = 1'b0; halt_wb = 1'b0;
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK); cyc("rst1", V_OFF, 0, 0);
    @(negedge CLK); cyc("rst2", V_OFF, 0, 0);

    @(negedge CLK); idle_inputs(); cyc("run", V_NORM, 0, 0);

    @(negedge CLK); dREN_ex = 1'b1; Rt_ex = 5'd5; Rs_id = 5'd5;
    cyc("lu_rs", V_LU, 0, 0);
    @(negedge CLK); Rt_ex = 5'd0; Rs_id = 5'd0;
    cyc("lu_r0", V_NORM, 1, 0);
    @(negedge CLK); Rt_ex = 5'd7; Rs_id = 5'd3; Rt_id = 5'd7;
    cyc("lu_rt", V_LU, 1, 0);
    @(negedge CLK); idle_inputs(); ihit = 1'b0;
    cyc("miss", V_MISS, 2, 0);
    @(negedge CLK); dREN_ex = 1'b1; Rt_ex = 5'd9; Rs_id = 5'd9;
    cyc("lu_miss", V_LU, 3, 0);
    @(negedge CLK); idle_inputs();
    cyc("run2", V_NORM, 4, 0);

    @(negedge CLK); RST = 1'b1; cyc("rst3", V_OFF, 4, 0);

    @(negedge CLK); idle_inputs(); dREN_mem = 1'b1;
    cyc("dw1", V_OFF, 0, 0);
    @(negedge CLK); cyc("dw2", V_OFF, 1, 0);
    @(negedge CLK); cyc("dw3", V_OFF, 2, 0);
    @(negedge CLK); dhit = 1'b1; cyc("dw_hit", V_NORM, 3, 0);

    @(negedge CLK); idle_inputs(); dWEN_mem = 1'b1; redirect_mem = 1'b1;
    cyc("dw_redir", V_OFF, 3, 0);
    @(negedge CLK); dhit = 1'b1; cyc("dw_redir_hit", V_REDIR, 4, 0);

    @(negedge CLK); idle_inputs(); redirect_mem = 1'b1; dREN_ex = 1'b1;
    Rt_ex = 5'd5; Rs_id = 5'd5;
    cyc("redir_lu", V_REDIR, 4, 1);
    @(negedge CLK); idle_inputs(); cyc("run3", V_NORM, 4, 2);

    @(negedge CLK); halt_mem = 1'b1; cyc("halt_mem", V_NORM, 4, 2);
    @(negedge CLK); halt_mem = 1'b0; cyc("drain1", V_DRAIN, 4, 2);
    @(negedge CLK); halt_wb = 1'b1; cyc("drain2", V_DRAIN, 5, 2);
    @(negedge CLK); halt_wb = 1'b0; cyc("halt1", V_HALTED, 6, 2);
    @(negedge CLK); ihit = 1'b0; cyc("halt2", V_HALTED, 6, 2);
    @(negedge CLK); RST = 1'b1; cyc("halt_rst", V_OFF, 6, 2);
    @(negedge CLK); idle_inputs(); cyc("post_halt", V_NORM, 0, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); ihit = 1'b0;
      cyc("sat_miss", V_MISS, (i < 15) ? i : 15, 0);
    end
    @(negedge CLK); ihit = 1'b1; cyc("sat_end", V_NORM, 15, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller that drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches and the PC write enable. It resolves instruction-fetch waits, data-memory waits, load-use hazards, branch/jump redirects and halt draining into one consistent per-cycle control vector. It holds a small state machine for multi-cycle conditions (dcache wait, halt drain, halted) and keeps saturating stall/flush performance counters. It sits between the datapath stage outputs and the pipeline latch block.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports (one clock CLK; reset RST is synchronous and active-high):
- CLK  in  1  core clock; all state changes on rising edge.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  instruction fetch for current PC completes this cycle.
- dhit  in  1  data access in MEM completes this cycle.
- dREN_mem, dWEN_mem  in  1 each  MEM-stage load/store request.
- dREN_ex  in  1  EX-stage instruction is a load.
- Rt_ex  in  5  EX-stage load destination register.
- Rs_id, Rt_id  in  5 each  ID-stage source registers.
- redirect_mem  in  1  MEM-stage branch mispredict or jr/jump correction; PC target supplied by datapath.
- halt_mem  in  1  halt instruction in MEM.
- halt_wb  in  1  halt instruction in WB.
- pc_en  out  1  PC register write enable.
- enable_ifid, enable_idex, enable_exmem, enable_memwb  out  1 each  latch advance enables.
- flush_ifid, flush_idex, flush_exmem  out  1 each  latch clear (bubble insert); flush overrides enable in the latch.
- halted  out  1  core stopped.
- stall_cycles  out  CNT_W  cycles with pc_en low while not HALT.
- flush_events  out  CNT_W  number of redirect flushes.

## Operation
- States: RUN, DWAIT, DRAIN, HALT. Reset → RUN, counters 0.
- Outputs are combinational from state and current inputs (same-cycle response); state and counters registered.
- While RST high: all enables 0, all flushes 0, pc_en 0, halted 0; counters held at 0.
- Priority per cycle in RUN/DRAIN, highest first:
  1. Dmem wait: (dREN_mem|dWEN_mem)&!dhit → every enable 0, every flush 0, pc_en 0; next state DWAIT (RUN) or stays DRAIN.
  2. Redirect: redirect_mem → flush_ifid, flush_idex, flush_exmem 1; enable_memwb 1; pc_en 1; flush_events+1. Does not override a pending halt drain.
  3. Load-use: dREN_ex & Rt_ex≠0 & (Rt_ex==Rs_id | Rt_ex==Rt_id) → pc_en 0, enable_ifid 0, flush_idex 1, enable_exmem/memwb 1.
  4. Fetch miss: !ihit → pc_en 0, flush_ifid 1, enable_idex/exmem/memwb 1.
  5. Otherwise all enables 1, flushes 0, pc_en 1.
- DWAIT: same freeze as rule 1 until dhit; on dhit cycle output vector equals RUN evaluation of rules 2–5 and next state RUN.
- halt_mem in RUN with no dmem wait → DRAIN. In DRAIN pc_en 0, flush_ifid 1, flush_idex 1 on top of rules above; halt_wb → HALT.
- HALT: all enables 0, flushes 0, pc_en 0, halted 1; exits only via RST.
- stall_cycles increments every non-reset cycle with pc_en 0 and state≠HALT; both counters saturate at all-ones.

## Timing
- Control vector valid in the same cycle as causing inputs; latches act on the following edge.
- Load-use produces exactly one bubble when the load advances; two cycles if combined with fetch miss is not possible (load-use wins, fetch retried).
- Redirect + load-use same cycle: redirect wins; load-use bubble discarded.
- Redirect + dmem wait same cycle: wait wins; redirect re-evaluated when dhit.
- halt_mem and halt_wb same cycle impossible; halt_wb in RUN ignored.
- RST asserted mid-DWAIT/DRAIN/HALT: next cycle RUN, counters 0.

## Test plan
- Reset: RST high 2 cycles → pc_en 0, all enables 0, halted 0, stall_cycles 0; release with ihit 1 → all enables 1, pc_en 1.
- Load-use: dREN_ex 1, Rt_ex 5, Rs_id 5 for 1 cycle → pc_en 0, enable_ifid 0, flush_idex 1; Rt_ex 0 same case → no stall.
- Dmem wait: dREN_mem 1, dhit 0 for 3 cycles then 1 → state DWAIT, all enables 0 for 3 cycles, stall_cycles 3, back to RUN.
- Redirect during load-use: redirect_mem 1 with hazard → flush_ifid/idex/exmem 1, pc_en 1, flush_events 1.
- Halt drain: halt_mem 1, two cycles later halt_wb 1 → DRAIN then HALT, halted 1 held until RST.
- Saturation: CNT_W 4, hold !ihit 20 cycles → stall_cycles stops at 15.
